// File: rtl/fire_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fire_cfg_pkg
// Shared definitions for the fire-module schedulers (squeeze, expand1x1,
// expand3x3): the per-fire layer geometry table, beat/pass widths, the
// scheduler FSM state type and the control beat carried down the MAC pipe.
// ---------------------------------------------------------------------------
package fire_cfg_pkg;

    localparam int unsigned CH_PER_BEAT   = 8;   // input channels per image word
    localparam int unsigned FILT_PER_PASS = 16;  // filters per weight fetch / output word
    localparam int unsigned CH_SHIFT      = $clog2(CH_PER_BEAT);
    localparam int unsigned FILT_SHIFT    = $clog2(FILT_PER_PASS);

    typedef int unsigned fire_tab_t [8];

    // Indexed by firesel.
    localparam fire_tab_t FIRE_IN_CH   = '{16, 128, 128, 256, 256, 384, 384, 512};
    localparam fire_tab_t FIRE_IN_SIZE = '{55, 55, 27, 27, 13, 13, 13, 13};
    localparam fire_tab_t FIRE_FILT    = '{64, 16, 32, 32, 48, 48, 64, 64};

    // Pixel counts folded to constants so no multiplier is needed at run time.
    localparam fire_tab_t FIRE_NPIX = '{
        FIRE_IN_SIZE[0] * FIRE_IN_SIZE[0], FIRE_IN_SIZE[1] * FIRE_IN_SIZE[1],
        FIRE_IN_SIZE[2] * FIRE_IN_SIZE[2], FIRE_IN_SIZE[3] * FIRE_IN_SIZE[3],
        FIRE_IN_SIZE[4] * FIRE_IN_SIZE[4], FIRE_IN_SIZE[5] * FIRE_IN_SIZE[5],
        FIRE_IN_SIZE[6] * FIRE_IN_SIZE[6], FIRE_IN_SIZE[7] * FIRE_IN_SIZE[7]
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    // Loop bounds of one layer run.
    typedef struct packed {
        logic [7:0]  chcyc;    // channel beats per pixel
        logic [11:0] npix;     // output pixels per filter group
        logic [7:0]  filtcyc;  // filter groups
    } fire_geom_t;

    // One issued beat as seen by the MAC array.
    typedef struct packed {
        logic       valid;
        logic       clr;
        logic       last;
        logic [7:0] fg;
    } ctrl_beat_t;

    function automatic fire_geom_t fire_geom(input logic [2:0] sel);
        fire_geom_t g;
        g.chcyc   = 8'(FIRE_IN_CH[sel] >> CH_SHIFT);
        g.npix    = 12'(FIRE_NPIX[sel]);
        g.filtcyc = 8'(FIRE_FILT[sel] >> FILT_SHIFT);
        return g;
    endfunction

endpackage

// File: rtl/expand_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// expand_ctrl_pipe
// DEPTH-deep delay line for the MAC control beat, so valid/clr/last/filter
// group arrive together with the read data. The whole line freezes on stall.
//   clk, rst : clock, synchronous active-high reset
//   stall_i  : hold every stage
//   beat_i   : control beat issued this cycle
//   beat_o   : control beat reaching the MAC array
// ---------------------------------------------------------------------------
module expand_ctrl_pipe
    import fire_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_i,
    input  ctrl_beat_t beat_i,
    output ctrl_beat_t beat_o
);

    ctrl_beat_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every stage is cleared, not just valid, so an aborted run
            // leaves no stale flags or filter group behind.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!stall_i) begin
            stage_q[0] <= beat_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign beat_o = stage_q[DEPTH-1];

endmodule

// File: rtl/expand1x1_sched.sv
// ---------------------------------------------------------------------------
// expand1x1_sched
// Sequencer for the fire expand-1x1 datapath. Walks channel beats (inner),
// output pixels, then 16-filter groups (outer); issues image/weight word
// addresses one beat per unstalled cycle and delays MAC control by RD_LAT.
//   clk, rst        : clock, synchronous active-high reset
//   start, firesel  : launch a run with the given fire config (IDLE only)
//   stall           : back-pressure, freezes issue and control pipe
//   busy, done      : run in progress / one-cycle end pulse
//   imgaddr/wgtaddr : read addresses of the beat being issued
//   filtgrp, mac_en, mac_clr, mac_last : control aligned with read data
// Optional: define EXPAND_SCHED_PERF_EN to add perf_cycles / perf_stalls.
// ---------------------------------------------------------------------------
module expand1x1_sched
    import fire_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        firesel,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] imgaddr,
    output logic [ADDR_W-1:0] wgtaddr,
    output logic [7:0]        filtgrp,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mac_last
`ifdef EXPAND_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    sched_state_e      state_q, state_d;
    logic [2:0]        sel_q;
    fire_geom_t        geom_q;
    logic [7:0]        ch_q, ch_d, fg_q, fg_d;
    logic [11:0]       pix_q, pix_d;
    logic [ADDR_W-1:0] img_q, img_d, wgt_q, wgt_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;  // fg * chcyc
    logic [2:0]        drain_q, drain_d;
    logic              busy_q, done_q;

    logic accept, last_ch, last_pix, last_fg;

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_ch  = (ch_q == geom_q.chcyc - 8'd1);
    assign last_pix = (pix_q == geom_q.npix - 12'd1);
    assign last_fg  = (fg_q == geom_q.filtcyc - 8'd1);

    always_comb begin
        // NOTE: defaults first, so paths that do not assign a signal hold it
        // rather than infer a latch.
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        fg_d    = fg_q;
        img_d   = img_q;
        wgt_d   = wgt_q;
        wbase_d = wbase_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_RUN;
                ch_d    = '0;
                pix_d   = '0;
                fg_d    = '0;
                img_d   = '0;
                wgt_d   = '0;
                wbase_d = '0;
                drain_d = '0;
            end
            ST_RUN: if (!stall) begin
                if (last_ch) begin
                    ch_d  = '0;
                    wgt_d = wbase_q;
                    if (last_pix) begin
                        // Next filter group: image walk restarts, weights move on.
                        pix_d   = '0;
                        img_d   = '0;
                        fg_d    = fg_q + 8'd1;
                        wbase_d = wbase_q + ADDR_W'(geom_q.chcyc);
                        wgt_d   = wbase_q + ADDR_W'(geom_q.chcyc);
                        if (last_fg) state_d = ST_DRAIN;
                    end else begin
                        pix_d = pix_q + 12'd1;
                        img_d = img_q + ADDR_W'(1);
                    end
                end else begin
                    ch_d  = ch_q + 8'd1;
                    img_d = img_q + ADDR_W'(1);
                    wgt_d = wgt_q + ADDR_W'(1);
                end
            end
            // Wait until the last issued beat has left the control pipe.
            ST_DRAIN: if (!stall) begin
                if (drain_q == 3'(RD_LAT - 1)) state_d = ST_DONE;
                else                          drain_d = drain_q + 3'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            geom_q  <= '0;
            ch_q    <= '0;
            pix_q   <= '0;
            fg_q    <= '0;
            img_q   <= '0;
            wgt_q   <= '0;
            wbase_q <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every register samples the
            // values from before this edge regardless of statement order.
            state_q <= state_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            fg_q    <= fg_d;
            img_q   <= img_d;
            wgt_q   <= wgt_d;
            wbase_q <= wbase_d;
            drain_q <= drain_d;
            // busy covers everything from LOAD up to and including the done pulse.
            busy_q  <= (state_d != ST_IDLE) || (state_q == ST_DONE);
            done_q  <= (state_q == ST_DONE);
            if (accept)              sel_q  <= firesel;
            if (state_q == ST_LOAD)  geom_q <= fire_geom(sel_q);
        end
    end

    ctrl_beat_t issue_beat, mac_beat;

    assign issue_beat.valid = (state_q == ST_RUN);
    assign issue_beat.clr   = (ch_q == 8'd0);
    assign issue_beat.last  = last_ch;
    assign issue_beat.fg    = fg_q;

    expand_ctrl_pipe #(
        .DEPTH (RD_LAT)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall),
        .beat_i  (issue_beat),
        .beat_o  (mac_beat)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign imgaddr  = img_q;
    assign wgtaddr  = wgt_q;
    assign filtgrp  = mac_beat.fg;
    // The frozen beat is masked, not lost: it reappears once stall drops.
    assign mac_en   = mac_beat.valid & ~stall;
    assign mac_clr  = mac_beat.valid & mac_beat.clr & ~stall;
    assign mac_last = mac_beat.valid & mac_beat.last & ~stall;

`ifdef EXPAND_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (busy_q) begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (stall) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_expand1x1_sched.sv
// ---------------------------------------------------------------------------
// tb_expand1x1_sched
// Randomized self-checking bench for expand1x1_sched. A reference model
// expands the loop nest (fg, pix, ch) into the expected beat list; a monitor
// pairs each MAC beat with the addresses issued RD_LAT unstalled cycles
// earlier and compares against that list.
// ---------------------------------------------------------------------------
module tb_expand1x1_sched;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        firesel = '0;
    logic              stall = 1'b0;
    logic              busy, done, mac_en, mac_clr, mac_last;
    logic [ADDR_W-1:0] imgaddr, wgtaddr;
    logic [7:0]        filtgrp;
`ifdef EXPAND_SCHED_PERF_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    expand1x1_sched #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .firesel  (firesel),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .imgaddr  (imgaddr),
        .wgtaddr  (wgtaddr),
        .filtgrp  (filtgrp),
        .mac_en   (mac_en),
        .mac_clr  (mac_clr),
        .mac_last (mac_last)
`ifdef EXPAND_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned img;
        int unsigned wgt;
        int unsigned fg;
        bit          clr;
        bit          last;
    } beat_t;

    int unsigned in_ch   [8] = '{16, 128, 128, 256, 256, 384, 384, 512};
    int unsigned in_size [8] = '{55, 55, 27, 27, 13, 13, 13, 13};
    int unsigned n_filt  [8] = '{64, 16, 32, 32, 48, 48, 64, 64};

    beat_t exp_q [$];
    int    exp_total;

    task automatic build_model(input int sel);
        int unsigned chcyc, npix, fcyc;
        beat_t b;
        exp_q.delete();
        chcyc = in_ch[sel] / 8;
        npix  = in_size[sel] * in_size[sel];
        fcyc  = n_filt[sel] / 16;
        for (int unsigned fg = 0; fg < fcyc; fg++)
            for (int unsigned pix = 0; pix < npix; pix++)
                for (int unsigned ch = 0; ch < chcyc; ch++) begin
                    b.img  = pix * chcyc + ch;
                    b.wgt  = fg * chcyc + ch;
                    b.fg   = fg;
                    b.clr  = (ch == 0);
                    b.last = (ch == chcyc - 1);
                    exp_q.push_back(b);
                end
        exp_total = exp_q.size();
    endtask

    // ---------------- monitor ----------------
    bit          mon_on = 1'b0;
    int          start_cyc = 0;
    int          mon_rel;
    int          mac_cnt, clr_cnt, last_cnt, done_cnt, done_rel, busy_cnt, first_rel;
    bit          beat_bad;
    logic [63:0] hist [$];
    logic [63:0] first_pairs [4];
    beat_t       eb;
    int          nf_before;

    always @(negedge clk) begin
        if (mon_on) begin
            mon_rel = cyc - start_cyc;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_rel = mon_rel;
            end
            if (stall) begin
                check("mac_en_while_stalled", 96'(mac_en), 96'(0));
            end else begin
                hist.push_back({imgaddr, wgtaddr});
                if (hist.size() > RD_LAT + 1) void'(hist.pop_front());
                if (mac_en) begin
                    if (mac_cnt == 0) first_rel = mon_rel;
                    if (mac_cnt < 4) first_pairs[mac_cnt] = hist[0];
                    mac_cnt++;
                    clr_cnt  += int'(mac_clr);
                    last_cnt += int'(mac_last);
                    if (exp_q.size() == 0) begin
                        check("beat_overflow", 96'(mac_cnt), 96'(exp_total));
                    end else begin
                        eb = exp_q.pop_front();
                        if (!beat_bad) begin
                            nf_before = n_fail;
                            check("beat", 96'({hist[0], filtgrp, mac_clr, mac_last}),
                                  96'({eb.img, eb.wgt, 8'(eb.fg), eb.clr, eb.last}));
                            if (n_fail != nf_before) beat_bad = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    int nstall;

    task automatic start_layer(input logic [2:0] sel);
        @(posedge clk); #1;
        build_model(sel);
        mac_cnt = 0; clr_cnt = 0; last_cnt = 0; done_cnt = 0; busy_cnt = 0;
        done_rel = -1; first_rel = -1; beat_bad = 1'b0; nstall = 0;
        hist.delete();
        firesel   = sel;
        start     = 1'b1;
        stall     = 1'b0;
        start_cyc = cyc;
        mon_on    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Stall and disturbance are applied only between the first issue and the
    // final MAC beat, so every stalled cycle stretches the run by one.
    task automatic run_to_done(input int stall_pct, input bit disturb, input int budget);
        int k = 0;
        int rel_now;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            rel_now = cyc - start_cyc;
            stall = 1'b0;
            start = 1'b0;
            if (rel_now >= 2 && mac_cnt < exp_total) begin
                if ($urandom_range(99) < stall_pct) begin
                    stall = 1'b1;
                    nstall++;
                end
                if (disturb) begin
                    start   = ($urandom_range(3) == 0);
                    firesel = 3'($urandom);
                end
            end
            k++;
        end
        stall = 1'b0;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("done_pulse_count", 96'(done_cnt), 96'(1));
    endtask

    task automatic check_totals(input string tag, input int beats, input int per_flag);
        check({tag, "_mac_en"},   96'(mac_cnt),  96'(beats));
        check({tag, "_mac_clr"},  96'(clr_cnt),  96'(per_flag));
        check({tag, "_mac_last"}, 96'(last_cnt), 96'(per_flag));
        check({tag, "_model_drained"}, 96'(exp_q.size()), 96'(0));
        check({tag, "_done_cycle"}, 96'(done_rel), 96'(beats + RD_LAT + 3 + nstall));
        check({tag, "_busy_cycles"}, 96'(busy_cnt), 96'(beats + RD_LAT + 3 + nstall));
    endtask

    initial begin
        int k;
        int m_at;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 96'({busy, done, mac_en, mac_clr, mac_last, filtgrp, imgaddr, wgtaddr}), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 96'({busy, done, mac_en}), 96'(0));

        // firesel 0, no stall: exact timing and first addresses
        start_layer(3'd0);
        run_to_done(0, 1'b0, 30000);
        check("f0_first_mac_en", 96'(first_rel), 96'(2 + RD_LAT));
        check("f0_first_pair0", 96'(first_pairs[0]), 96'({32'd0, 32'd0}));
        check("f0_first_pair1", 96'(first_pairs[1]), 96'({32'd1, 32'd1}));
        check("f0_first_pair2", 96'(first_pairs[2]), 96'({32'd2, 32'd0}));
        check("f0_first_pair3", 96'(first_pairs[3]), 96'({32'd3, 32'd1}));
        check_totals("f0", 24200, 12100);
        check("f0_done_abs", 96'(done_rel), 96'(24205));

        // firesel 4, random stall plus start/firesel noise while busy
        start_layer(3'd4);
        run_to_done(25, 1'b1, 40000);
        check_totals("f4_stall", 16224, 507);
        check("f4_idle_after", 96'({busy, mac_en}), 96'(0));
`ifdef EXPAND_SCHED_PERF_EN
        check("perf_stalls", 96'(perf_stalls), 96'(nstall));
        check("perf_cycles", 96'(perf_cycles), 96'(16224 + RD_LAT + 3 + nstall));
        repeat (5) @(posedge clk);
        #1;
        check("perf_cycles_hold", 96'(perf_cycles), 96'(16224 + RD_LAT + 3 + nstall));
`endif

        // Abort with reset at beat 1000 of firesel 4
        start_layer(3'd4);
        k = 0;
        while (mac_cnt < 1000 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_reached_1000", 96'(mac_cnt), 96'(1000));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 96'(busy), 96'(0));
        check("abort_mac_en", 96'(mac_en), 96'(0));
        m_at = mac_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 96'(done_cnt), 96'(0));
        check("abort_no_mac_en", 96'(mac_cnt), 96'(m_at));

        // Restart after abort: must begin cleanly at address 0
        start_layer(3'd2);
        k = 0;
        while (mac_cnt < 40 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("restart_beats", 96'(mac_cnt >= 40), 96'(1));
        check("restart_first_mac_en", 96'(first_rel), 96'(2 + RD_LAT));
        check("restart_pair0", 96'(first_pairs[0]), 96'({32'd0, 32'd0}));
        mon_on = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("final_idle", 96'({busy, mac_en}), 96'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
